// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
// Holds the parity_mode encodings, the transmit FSM state type and the
// minimum supported data length.
package uart_pkg;

  localparam int unsigned DATA_MIN = 5;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART shifter.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, wdata     write request and data (ignored when full unless popping)
//   pop, rdata      read request; rdata is registered and valid the cycle after pop
//   full, empty     occupancy flags
//   level           number of entries held
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign rdata = rdata_q;

  always_comb begin
    do_pop   = pop && !empty;
    // A pop frees the slot being written, so push-while-full is legal then.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rdata_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with run-time data length, parity and stop-bit count.
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   clk_div            clk cycles per bit (0 and 1 both mean 1)
//   data_bits          data length, clamped to DATA_MIN..DATA_MAX
//   parity_mode        0 none, 1 even, 2 odd, 3 none
//   stop2              two stop bits when set
//   tx_data, tx_valid  word push; accepted when tx_ready
//   tx_ready           FIFO not full
//   tx                 registered serial output, idle high
//   clear_req          pulse when a word moves from FIFO to the shifter
//   tx_done            pulse in the last cycle of the final stop bit
//   busy               frame in progress or FIFO non-empty
//   fifo_level         FIFO occupancy
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_MAX   = 9,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic [3:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic [DATA_MAX-1:0]           tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          clear_req,
  output logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  tx_state_e           state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d, div_eff;
  logic [3:0]          bit_q, bit_d;
  logic [3:0]          nbits_q, nbits_d, nbits_clamp;
  logic [1:0]          pmode_q, pmode_d;
  logic                stop2_q, stop2_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic [DATA_MAX-1:0] data_mask, fifo_rdata, word;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                cnt_last, par_en, stop_last, launch, done;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign tx        = tx_q;
  assign clear_req = fifo_pop;
  assign tx_done   = done;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    div_eff = (clk_div > DIV_W'(1)) ? clk_div : DIV_W'(1);
    if (data_bits < 4'(DATA_MIN)) begin
      nbits_clamp = 4'(DATA_MIN);
    end else if (data_bits > 4'(DATA_MAX)) begin
      nbits_clamp = 4'(DATA_MAX);
    end else begin
      nbits_clamp = data_bits;
    end
    for (int unsigned i = 0; i < DATA_MAX; i++) begin
      data_mask[i] = (i < 32'(nbits_q));
    end
    word      = fifo_rdata & data_mask;
    cnt_last  = (cnt_q == div_q - DIV_W'(1));
    par_en    = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
    stop_last = stop2_q ? (bit_q == 4'd1) : 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
    bit_d    = bit_q;
    div_d    = div_q;
    nbits_d  = nbits_q;
    pmode_d  = pmode_q;
    stop2_d  = stop2_q;
    par_d    = par_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    launch   = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) launch = 1'b1;
      end
      START: begin
        // The FIFO read port is registered, so the popped word is only
        // visible here; the shifter and parity are loaded as START ends.
        if (cnt_last) begin
          shift_d = word;
          par_d   = (^word) ^ (pmode_q == PAR_ODD);
          tx_d    = word[0];
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt_last) begin
          if (bit_q == nbits_q - 4'd1) begin
            bit_d = '0;
            if (par_en) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (cnt_last) begin
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_last) begin
          if (stop_last) begin
            done = 1'b1;
            if (!fifo_empty) begin
              launch = 1'b1;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Pop and configuration capture shared by IDLE and back-to-back STOP.
    if (launch) begin
      fifo_pop = 1'b1;
      div_d    = div_eff;
      nbits_d  = nbits_clamp;
      pmode_d  = parity_mode;
      stop2_d  = stop2;
      cnt_d    = '0;
      bit_d    = '0;
      tx_d     = 1'b0;
      state_d  = START;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      div_q   <= DIV_W'(1);
      nbits_q <= 4'(DATA_MIN);
      pmode_q <= '0;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      nbits_q <= nbits_d;
      pmode_q <= pmode_d;
      stop2_q <= stop2_d;
      par_q   <= par_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: accepted words are queued with the
// configuration in force at push time; a line monitor decodes each frame
// from tx and compares it against a frame built from the UART framing rules.
module tb_uart_tx_param;

  localparam int unsigned DATA_MAX   = 9;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DIV_W      = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DIV_W-1:0] clk_div = 32'd8;
  logic [3:0]       data_bits = 4'd8;
  logic [1:0]       parity_mode = 2'd0;
  logic             stop2 = 1'b0;
  logic [8:0]       tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready, tx, clear_req, tx_done, busy;
  logic [2:0]       fifo_level;

  uart_tx_param #(
    .DATA_MAX   (DATA_MAX),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_div     (clk_div),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx          (tx),
    .clear_req   (clear_req),
    .tx_done     (tx_done),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  word;
    int unsigned nb;
    logic [1:0]  pm;
    logic        s2;
    int unsigned dv;
  } frame_t;

  frame_t      sb_q[$];
  int unsigned start_cyc[$];
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned cyc      = 0;
  int unsigned last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  function automatic frame_t mk_frame(input logic [8:0] w);
    frame_t f;
    f.word = w;
    if (data_bits < 4'd5)      f.nb = 5;
    else if (data_bits > 4'd9) f.nb = 9;
    else                       f.nb = int'(data_bits);
    f.pm = parity_mode;
    f.s2 = stop2;
    f.dv = (clk_div < 32'd2) ? 1 : int'(clk_div);
    return f;
  endfunction

  // Expected tx level for each cycle of the frame, index 0 = first start cycle.
  function automatic int unsigned build_frame(input frame_t f, output logic [127:0] v);
    logic        lv[$];
    int unsigned ones = 0;
    int unsigned n = 0;
    v = '1;
    lv.push_back(1'b0);
    for (int unsigned i = 0; i < f.nb; i++) begin
      lv.push_back(f.word[i]);
      if (f.word[i]) ones++;
    end
    if (f.pm == 2'd1) lv.push_back((ones % 2) == 1);
    if (f.pm == 2'd2) lv.push_back((ones % 2) == 0);
    lv.push_back(1'b1);
    if (f.s2) lv.push_back(1'b1);
    foreach (lv[k]) begin
      for (int unsigned r = 0; r < f.dv; r++) begin
        v[n] = lv[k];
        n++;
      end
    end
    return n;
  endfunction

  // Line monitor.
  logic         in_frame = 1'b0;
  logic         prev_clear = 1'b0;
  logic         done_ok;
  logic [127:0] exp_v, act_v;
  int unsigned  exp_len, idx;
  frame_t       cur;

  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_frame: tx low at cycle %0d, got a frame expected none pending", cyc);
        end else begin
          cur      = sb_q.pop_front();
          exp_len  = build_frame(cur, exp_v);
          act_v    = '1;
          idx      = 0;
          done_ok  = 1'b1;
          in_frame = 1'b1;
          start_cyc.push_back(cyc);
          n_checks++;
          if (prev_clear !== 1'b1) begin
            n_err++;
            $display("FAIL clear_req_before_start: word %h got %b expected 1", cur.word, prev_clear);
          end
        end
      end
      if (in_frame) begin
        act_v[idx] = tx;
        if (tx_done !== (idx == exp_len - 1)) done_ok = 1'b0;
        if (tx_done === 1'b1) last_done_cyc = cyc;
        if (idx == exp_len - 1) begin
          in_frame = 1'b0;
          n_checks++;
          if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL frame_bits: word %h len %0d got %h expected %h", cur.word, exp_len, act_v, exp_v);
          end
          n_checks++;
          if (!done_ok) begin
            n_err++;
            $display("FAIL tx_done_timing: word %h got misplaced pulse expected only at frame cycle %0d", cur.word, exp_len);
          end
        end else begin
          idx++;
        end
      end
    end
    prev_clear = clear_req;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] dv, input logic [3:0] nb, input logic [1:0] pm, input logic s2);
    clk_div     = dv;
    data_bits   = nb;
    parity_mode = pm;
    stop2       = s2;
  endtask

  // Called just after a posedge; holds tx_valid for one cycle.
  task automatic push_word(input logic [8:0] w, input bit acc);
    tx_valid = 1'b1;
    tx_data  = w;
    if (acc) sb_q.push_back(mk_frame(w));
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output int unsigned fall_cyc);
    bit seen = 1'b0;
    fall_cyc = 0;
    for (int unsigned t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        seen     = 1'b1;
        fall_cyc = cyc;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL idle_timeout: got busy after 5000 cycles expected idle");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned fc;
    int unsigned n;
    int unsigned base;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {tx, tx_ready, clear_req, tx_done, busy, fifo_level}, {5'b11000, 3'd0});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 8N1 baseline with pop/start latency.
    set_cfg(32'd8, 4'd8, 2'd0, 1'b0);
    tx_valid = 1'b1;
    tx_data  = 9'h041;
    sb_q.push_back(mk_frame(9'h041));
    @(negedge clk);
    chk("clear_req_push_cycle", clear_req, 1'b0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("clear_req_pop_cycle", clear_req, 1'b1);
    chk("tx_high_pop_cycle", tx, 1'b1);
    @(negedge clk);
    chk("tx_low_two_after_push", tx, 1'b0);
    wait_idle(fc);

    // Parity even / odd.
    set_cfg(32'd8, 4'd8, 2'd1, 1'b0);
    push_word(9'h041, 1'b1);
    wait_idle(fc);
    set_cfg(32'd8, 4'd8, 2'd2, 1'b0);
    push_word(9'h041, 1'b1);
    wait_idle(fc);

    // 7 data bits, two stop bits.
    set_cfg(32'd4, 4'd7, 2'd0, 1'b1);
    push_word(9'h08F, 1'b1);
    wait_idle(fc);

    // Divider 0 and 1 both give one cycle per bit.
    set_cfg(32'd0, 4'd8, 2'd0, 1'b0);
    push_word(9'h055, 1'b1);
    wait_idle(fc);
    set_cfg(32'd1, 4'd8, 2'd0, 1'b0);
    push_word(9'h055, 1'b1);
    wait_idle(fc);

    // FIFO full, drop, back-to-back frames.
    set_cfg(32'd2, 4'd8, 2'd0, 1'b0);
    start_cyc.delete();
    for (int unsigned i = 0; i < 5; i++) push_word(9'(8'hA0 + i), 1'b1);
    tx_valid = 1'b1;
    tx_data  = 9'h0FF;
    @(negedge clk);
    chk("full_level", fifo_level, 3'd4);
    chk("full_ready", tx_ready, 1'b0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("drop_level_unchanged", fifo_level, 3'd4);
    wait_idle(fc);
    chk("busy_fall_after_done", fc, last_done_cyc + 1);
    chk("b2b_frame_count", start_cyc.size(), 5);
    if (start_cyc.size() == 5) begin
      for (int unsigned k = 1; k < 5; k++) begin
        chk("b2b_no_gap", start_cyc[k] - start_cyc[k-1], 20);
      end
    end

    // Randomized bursts; single-word bursts also scramble config mid-frame.
    for (int unsigned it = 0; it < 30; it++) begin
      set_cfg($urandom_range(0, 5), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 5);
      for (int unsigned i = 0; i < n; i++) push_word(9'($urandom_range(0, 511)), 1'b1);
      if (n == 1) begin
        @(posedge clk); #1;
        set_cfg($urandom_range(0, 5), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      wait_idle(fc);
    end

    // Reset during DATA.
    set_cfg(32'd8, 4'd8, 2'd0, 1'b0);
    push_word(9'h0C3, 1'b1);
    push_word(9'h03C, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    base = sb_q.size();
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_level", fifo_level, 3'd0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_pending_words", base, 1);
    @(posedge clk); #1;
    push_word(9'h05A, 1'b1);
    wait_idle(fc);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised successor to the fixed 8N1 UART transmitter.
- Serialises words from a small internal FIFO onto a single TX line.
- Data length, parity and stop-bit count are configurable at run time; bit period comes from a programmable clock divider.
- Sits between the Wishbone/CSR-facing UART register block and the chip TX pad.

Parameters:
- DATA_MAX, 9, widest supported data word; tx_data width.
- FIFO_DEPTH, 4, FIFO entries (power of two, at least 2).
- DIV_W, 32, width of clk_div.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- clk_div  in  DIV_W  clk cycles per bit; values 0 and 1 both mean 1.
- data_bits  in  4  data length; legal 5..DATA_MAX, values outside the range are clamped.
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 none (reserved).
- stop2  in  1  0 one stop bit, 1 two stop bits.
- tx_data  in  DATA_MAX  word to send, LSB first; bits at and above data_bits are ignored.
- tx_valid  in  1  push request.
- tx_ready  out  1  FIFO not full.
- tx  out  1  serial output, idle high.
- clear_req  out  1  one-cycle pulse when a word moves from FIFO into the shifter.
- tx_done  out  1  one-cycle pulse in the last cycle of the final stop bit.
- busy  out  1  shifter active or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.

Behaviour:
- Reset: rst low at a clk edge gives tx=1, tx_ready=1, clear_req=0, tx_done=0, busy=0, fifo_level=0, FSM=IDLE, FIFO emptied, bit/cycle counters cleared.
  - Reset mid-frame aborts the frame; tx is high from the next cycle.
- Push: tx_valid&&tx_ready writes the FIFO. Pushes while full are dropped and the level is unchanged.
  - A simultaneous push and pop while full is allowed; level is unchanged.
- Config capture: clk_div, data_bits, parity_mode and stop2 are latched at the pop. Changes mid-frame affect only the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop, load the shifter, pulse clear_req, go to START.
  - START: tx=0 for div cycles.
  - DATA: tx=shift[0] for div cycles per bit, data_bits bits, LSB first.
  - PARITY: entered only when parity_mode is 1 or 2. tx = XOR of the data bits (even), or its inverse (odd), for div cycles.
  - STOP: tx=1 for div or 2*div cycles. tx_done pulses in the final cycle.
    - If the FIFO is non-empty, pop in that same cycle and go directly to START: no idle gap between frames.
    - Otherwise go to IDLE.
- Latency: a push into an empty FIFO while IDLE at cycle N gives the pop at N+1 and tx low at N+2.
- Counters: bit-period counter is DIV_W wide and wraps to 0 at div-1; the bit counter is 4 bits.
- Frame length: div*(1+data_bits+P+S), where P is 0/1 for parity and S is 1/2 stop bits.
- tx is driven from a flop: no combinational glitch.

Decomposition:
- Package uart_pkg holds:
  - parity_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the FSM state enum;
  - the DATA_MIN=5 constant.
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty/level, no first-word fall-through. It is instantiated once.
- The FSM, shifter and divider stay in uart_tx_param.

Test Plan:
- 8N1 baseline: clk_div=8, data_bits=8, parity 0, stop2=0, push 0x41 → tx low 8 cycles, then 1,0,0,0,0,0,1,0 at 8 cycles each, high 8; tx_done at the 80th frame cycle; clear_req one cycle before the start bit.
- Parity: push 0x41 with even parity → parity bit 0, frame 88 cycles. With odd parity → parity bit 1.
- Width/stop: data_bits=7, stop2=1, clk_div=4, push 0x8F → only 7 bits sent (1,1,1,1,0,0,0), stop high 8 cycles, frame 40 cycles.
- FIFO full/back-to-back:
  - Push 6 words on consecutive cycles while IDLE → word 1 popped, FIFO then holds 4 and tx_ready=0; word 6 is dropped.
  - Frames run with no gap between stop and start.
  - busy falls the cycle after the 5th frame's tx_done.
- Divider edge: clk_div=0 and clk_div=1 → one cycle per bit, 0x55 gives a 10-cycle 8N1 frame.
- Reset mid-frame: assert rst during DATA → next cycle tx=1, fifo_level=0, busy=0. After release, a new push sends a clean frame.
